// File: rtl/biquad_pkg.sv
// Shared constants and helpers for the time-shared direct-form-I biquad sequencer.
// FSM encoding, tap order, sign-magnitude sign rule and saturation bounds.
package biquad_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] SAT  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  // Feedback taps enter the sum negated, so their product sign flips once more.
  function automatic logic sm_neg(input logic coef_sign, input logic sample_sign,
                                  input logic fb_tap);
    return coef_sign ^ sample_sign ^ fb_tap;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/biquad_sat.sv
// Output scaling for the biquad accumulator: arithmetic shift by COEFWIDTH-2 and clamp.
// Define BIQUAD_ROUND_EN for round-half-up before the shift; otherwise truncation (floor).
module biquad_sat
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int ACCWIDTH  = DATAWIDTH + COEFWIDTH + 4
) (
  input  logic signed [ACCWIDTH-1:0]  acc,
  output logic signed [DATAWIDTH-1:0] y
);

  localparam int EW = ACCWIDTH + 1;
  localparam logic signed [EW-1:0] HI = EW'(sat_max(DATAWIDTH));
  localparam logic signed [EW-1:0] LO = EW'(sat_min(DATAWIDTH));
`ifdef BIQUAD_ROUND_EN
  localparam logic signed [EW-1:0] RND = EW'(longint'(1) <<< (COEFWIDTH - 3));
`endif

  // One guard bit keeps the rounding add from wrapping at full-scale accumulators.
  function automatic logic signed [EW-1:0] round_shift(input logic signed [ACCWIDTH-1:0] a);
    logic signed [EW-1:0] t;
    t = {a[ACCWIDTH-1], a};
`ifdef BIQUAD_ROUND_EN
    t = t + RND;
`endif
    return t >>> (COEFWIDTH - 2);
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] sat_clamp(input logic signed [EW-1:0] v);
    if (v > HI)      return HI[DATAWIDTH-1:0];
    else if (v < LO) return LO[DATAWIDTH-1:0];
    else             return v[DATAWIDTH-1:0];
  endfunction

  assign y = sat_clamp(round_shift(acc));

endmodule

// File: rtl/biquad_mac_sched.sv
// Direct-form-I biquad sequencer sharing one external unsigned multiplier over five taps.
// Output rounding is selected by BIQUAD_ROUND_EN inside biquad_sat (truncation by default).
module biquad_mac_sched
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int ACCWIDTH  = DATAWIDTH + COEFWIDTH + 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATAWIDTH-1:0]          in_data,
  input  logic [COEFWIDTH-1:0]          coef_b0,
  input  logic [COEFWIDTH-1:0]          coef_b1,
  input  logic [COEFWIDTH-1:0]          coef_b2,
  input  logic [COEFWIDTH-1:0]          coef_a1,
  input  logic [COEFWIDTH-1:0]          coef_a2,
  output logic [COEFWIDTH-2:0]          mul_a,
  output logic [DATAWIDTH+2:0]          mul_b,
  input  logic [DATAWIDTH+COEFWIDTH+1:0] mul_r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATAWIDTH-1:0]          out_data
);

  localparam int PW = DATAWIDTH + COEFWIDTH + 2;

  logic [1:0]                  state;
  logic [2:0]                  tap;
  logic signed [DATAWIDTH-1:0] x0, x1, x2, y1, y2;
  logic signed [ACCWIDTH-1:0]  acc;
  logic signed [ACCWIDTH-1:0]  prod_ext;
  logic signed [DATAWIDTH-1:0] y_sat;
  logic [COEFWIDTH-1:0]        coef_sel;
  logic signed [DATAWIDTH-1:0] samp_sel;
  logic [DATAWIDTH-1:0]        samp_mag;
  logic                        in_mac;
  logic                        neg;

  always_comb begin
    coef_sel = '0;
    samp_sel = '0;
    case (tap)
      TAP_B0: begin coef_sel = coef_b0; samp_sel = x0; end
      TAP_B1: begin coef_sel = coef_b1; samp_sel = x1; end
      TAP_B2: begin coef_sel = coef_b2; samp_sel = x2; end
      TAP_A1: begin coef_sel = coef_a1; samp_sel = y1; end
      TAP_A2: begin coef_sel = coef_a2; samp_sel = y2; end
      default: ;
    endcase
  end

  // Unsigned magnitude: the most negative sample maps to 2^(DATAWIDTH-1) without overflow.
  assign samp_mag = samp_sel[DATAWIDTH-1] ? DATAWIDTH'(-samp_sel) : DATAWIDTH'(samp_sel);
  assign in_mac   = (state == MAC);
  assign mul_a    = in_mac ? coef_sel[COEFWIDTH-2:0] : '0;
  assign mul_b    = in_mac ? {3'b000, samp_mag} : '0;
  assign neg      = sm_neg(coef_sel[COEFWIDTH-1], samp_sel[DATAWIDTH-1], tap >= TAP_A1);
  assign prod_ext = {{(ACCWIDTH-PW){1'b0}}, mul_r};
  assign in_ready = (state == IDLE) && !clear;

  biquad_sat #(
    .DATAWIDTH(DATAWIDTH),
    .COEFWIDTH(COEFWIDTH),
    .ACCWIDTH (ACCWIDTH)
  ) u_sat (
    .acc(acc),
    .y  (y_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tap       <= TAP_B0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      state     <= IDLE;
      tap       <= TAP_B0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x0    <= in_data;
          acc   <= '0;
          tap   <= TAP_B0;
          state <= MAC;
        end
        MAC: begin
          acc <= neg ? acc - prod_ext : acc + prod_ext;
          if (tap == TAP_A2) state <= SAT;
          else               tap   <= tap + 3'd1;
        end
        SAT: begin
          out_data  <= y_sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          // History advances only once the output is consumed; y1 takes the saturated value.
          x2        <= x1;
          x1        <= x0;
          y2        <= y1;
          y1        <= out_data;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_mac_sched.sv
// Scoreboard bench for biquad_mac_sched with a behavioural multiplier and biquad reference model.
// Honours BIQUAD_ROUND_EN when it is defined for the whole build.
module tb_biquad_mac_sched;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int PW = DW + CW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] cb0 = '0, cb1 = '0, cb2 = '0, ca1 = '0, ca2 = '0;
  logic [CW-2:0] mul_a;
  logic [DW+2:0] mul_b;
  logic [PW-1:0] mul_r;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int hs_n = 0;
  longint expq[$];
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  always #5 clk = ~clk;

  assign mul_r = PW'(mul_a) * PW'(mul_b);

  biquad_mac_sched #(.DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_b0  (cb0),
    .coef_b1  (cb1),
    .coef_b2  (cb2),
    .coef_a1  (ca1),
    .coef_a2  (ca2),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_r    (mul_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sm2l(input logic [CW-1:0] c);
    longint m;
    m = longint'(c[CW-2:0]);
    return c[CW-1] ? -m : m;
  endfunction

  function automatic longint model_y(input longint x);
    longint a, y;
    a = sm2l(cb0) * x + sm2l(cb1) * mx1 + sm2l(cb2) * mx2 - sm2l(ca1) * my1 - sm2l(ca2) * my2;
`ifdef BIQUAD_ROUND_EN
    a = a + (longint'(1) <<< (CW - 3));
`endif
    y = a >>> (CW - 2);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic model_flush();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // mode 0: expect model value, 1: expect literal lit, 2: sample will be discarded
  task automatic send(input longint x, input longint lit, input int mode);
    longint y;
    bit ok;
    ok = 0;
    in_data  = DW'(x);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (mode != 2) begin
      y = model_y(x);
      expq.push_back(mode == 1 ? lit : y);
      mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
    chk("drain_left", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_flush();
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      hs_n++;
      if (expq.size() == 0) chk("unexpected_out", 1, 0);
      else chk("y", longint'($signed(out_data)), expq.pop_front());
    end
  end

  initial begin
    longint held;
    int lat, hs0;
    bit seen;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Unity b0: pass-through and acceptance-to-valid latency (handshake cycle = cycle 0)
    cb0 = 16'd16384;
    send(1000, 1000, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin lat = i + 1; break; end
    end
    chk("latency", lat, 7);
    drain();
    send(-1000, -1000, 1);
    drain();

    // One-pole feedback with a1 = -0.5
    do_clear();
    ca1 = 16'hA000;
    send(1000, 1000, 1);
    send(0, 500, 1);
    send(0, 250, 1);
    drain();

    // Saturation at both rails, then saturated feedback
    do_clear();
    cb0 = 16'd32767; ca1 = 16'd0;
    send(32767, 32767, 1);
    send(-32768, -32768, 1);
    drain();
    cb0 = 16'd0; ca1 = 16'hA000;
    send(0, -16384, 1);
    drain();

    // Backpressure: output held, input refused, single handshake on release
    do_clear();
    cb0 = 16'd16384; ca1 = 16'd0;
    out_ready = 1'b0;
    send(1234, 1234, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin seen = 1; break; end
    end
    chk("bp_valid_seen", seen, 1);
    held = longint'($signed(out_data));
    in_data = 16'd777;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_data_stable", longint'($signed(out_data)), held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    hs0 = hs_n;
    out_ready = 1'b1;
    send(777, 777, 1);
    chk("bp_single_hs", hs_n - hs0, 1);
    chk("bp_valid_dropped", out_valid, 0);
    drain();

    // Clear during tap 2 discards the sample and flushes history
    cb0 = 16'd0; cb1 = 16'd16384;
    send(5000, 0, 2);
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_flush();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("clr_no_valid", seen, 0);
    @(posedge clk);
    #1;
    send(1000, 0, 1);
    send(0, 1000, 1);
    drain();

    // Half gain on a small odd sample exposes rounding versus truncation
    do_clear();
    cb0 = 16'd8192; cb1 = 16'd0;
`ifdef BIQUAD_ROUND_EN
    send(3, 2, 1);
`else
    send(3, 1, 1);
`endif
    drain();

    // Random coefficients and samples against the reference model
    do_clear();
    cb0 = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 12000))};
    cb1 = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 12000))};
    cb2 = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 12000))};
    ca1 = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 6000))};
    ca2 = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 6000))};
    for (int i = 0; i < 20; i++) begin
      send(longint'($urandom_range(0, 65535)) - 32768, 0, 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biquad_mac_sched.md
Name: biquad_mac_sched

Overview:
- Sequencer that time-shares one unsigned multiplier (operand widths COEFWIDTH-1 x DATAWIDTH+3, product DATAWIDTH+COEFWIDTH+2) across the five products of a direct-form-I biquad.
- Computes y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
- Owns the delay line, accumulator, output scaling and saturation.
- Sits between the sample stream and the multiplier instance inside the biquad section.

Parameters:
DATAWIDTH, 16, signed two's-complement sample width (x and y)
COEFWIDTH, 16, coefficient width; sign-magnitude, MSB = sign, magnitude Q1.(COEFWIDTH-2)
ACCWIDTH, DATAWIDTH+COEFWIDTH+4, signed accumulator width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
clear  input  1  synchronous flush of delay line and FSM
in_valid  input  1  x sample valid
in_ready  output  1  block can accept x
in_data  input  DATAWIDTH  x[n], signed
coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  input  COEFWIDTH each  sign-magnitude coefficients, quasi-static
mul_a  output  COEFWIDTH-1  coefficient magnitude to multiplier
mul_b  output  DATAWIDTH+3  sample magnitude, zero-extended, to multiplier
mul_r  input  DATAWIDTH+COEFWIDTH+2  product; combinational, valid same cycle
out_valid  output  1  y[n] valid
out_ready  input  1  downstream accepts y
out_data  output  DATAWIDTH  y[n], signed, saturated

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_data=0; mul_a=0; mul_b=0; x1, x2, y1, y2, acc, tap=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch x0=in_data, clear acc, tap=0, go MAC.
  - MAC: in_ready=0. One tap per cycle, tap 0..4 = (b0,x0), (b1,x1), (b2,x2), (a1,y1), (a2,y2).
  - After tap 4, go SAT.
  - SAT: compute y, load out_data, set out_valid, go OUT.
  - OUT: hold out_data/out_valid until out_ready. On the handshake: x2<=x1, x1<=x0, y2<=y1, y1<=y; go IDLE.
- Per tap (combinational drive, registered accumulate):
  - mul_a = coef magnitude; mul_b = |sample|. |-2^(DATAWIDTH-1)| is representable.
  - Product sign = coef sign XOR sample sign; additionally inverted for the a1/a2 taps.
  - acc <= acc +/- zero-extended mul_r.
- Latency: sample accepted at edge T; taps occupy T+1..T+5; out_valid high from T+7 (SAT at T+6). Minimum 8 cycles per sample with out_ready tied high.
- Scaling: y = acc >>> (COEFWIDTH-2), arithmetic shift.
  - Saturate to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
  - The saturated value, not the raw value, is fed back into y1.
- mul_a/mul_b are 0 outside MAC, so an idle multiplier does not toggle.
- clear (any state): zero x1, x2, y1, y2, acc; drop out_valid; go IDLE next cycle. Any sample in flight is discarded. clear has priority over in_valid in the same cycle.
- Coefficient changes mid-sample are not protected. They are sampled at the tap that uses them.
- reset mid-operation: immediate return to reset values; no output is produced.

Optional Feature:
- Macro: BIQUAD_ROUND_EN.
- Defined: in SAT, add 2^(COEFWIDTH-3) to acc before the shift (round-half-up), then saturate.
- Undefined: truncation (floor) only.

Decomposition:
- Package biquad_pkg holds:
  - state encoding constants: IDLE, MAC, SAT, OUT
  - tap index constants: TAP_B0..TAP_A2
  - the sign-magnitude helper function
  - saturation bounds derived from DATAWIDTH
- One natural sub-module: biquad_sat (shift, optional round, clamp), purely combinational.
- The multiplier stays an external instance wired to mul_a/mul_b/mul_r.

Test Plan:
- b0=16384 (1.0), others 0; x=1000 with out_ready=1 -> out_data=1000, out_valid asserted 7 cycles after acceptance; x=-1000 -> -1000.
- b0=16384, a1=sign|8192 (-0.5); impulse 1000 then 0, 0 -> outputs 1000, 500, 250.
- b0=32767, x=32767 -> out_data=32767 (saturated); x=-32768 -> -32768; following sample uses y1=saturated value.
- out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is not accepted; release -> single handshake, next sample accepted.
- clear asserted during MAC tap 2 -> no out_valid for that sample; next impulse x=1000 with b1=16384 gives y=0 then 1000 (history flushed).
- With BIQUAD_ROUND_EN: b0=8192 (0.5), x=3 -> 2; without the macro -> 1.
